// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry valid/ready skid buffer.
// Decodes the RISC-V immediate formats (I/S/B/U/J and Zicsr zimm), flags unknown
// opcodes, and precomputes the PC-relative target before buffering each entry.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int EN_ZICSR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U    = 3'd4, F_J = 3'd5, F_Z = 3'd6;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_MISC  = 7'b0001111,
                           OP_IMM   = 7'b0010011, OP_AUIPC = 7'b0010111,
                           OP_IMM32 = 7'b0011011, OP_STORE = 7'b0100011,
                           OP_OP    = 7'b0110011, OP_LUI   = 7'b0110111,
                           OP_OP32  = 7'b0111011, OP_BR    = 7'b1100011,
                           OP_JALR  = 7'b1100111, OP_JAL   = 7'b1101111,
                           OP_SYS   = 7'b1110011;

    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm, dec_tgt;
    logic [2:0]      dec_fmt;
    logic            dec_ill, pcrel, is_lui;

    // Combinational decode of the incoming word; every immediate is first built as
    // a 32-bit signed value so one sign-extension covers both XLEN choices.
    always_comb begin
        imm32   = '0;
        dec_fmt = F_NONE;
        dec_ill = 1'b0;
        pcrel   = 1'b0;
        is_lui  = 1'b0;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec_fmt = F_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    dec_fmt = F_I;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OP_STORE: begin
                dec_fmt = F_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BR: begin
                dec_fmt = F_B;
                pcrel   = 1'b1;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_fmt = F_J;
                pcrel   = 1'b1;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = F_U;
                pcrel   = (in_instr[6:0] == OP_AUIPC);
                is_lui  = (in_instr[6:0] == OP_LUI);
                imm32   = {in_instr[31:12], 12'b0};
            end
            OP_SYS: begin
                // zimm is 5 bits with a zero top, so the shared sign-extension is harmless
                if (EN_ZICSR != 0 && in_instr[14]) begin
                    dec_fmt = F_Z;
                    imm32   = {27'b0, in_instr[19:15]};
                end
            end
            OP_OP, OP_MISC: ;
            OP_OP32: dec_ill = (XLEN != 64);
            default: dec_ill = 1'b1;
        endcase
        dec_imm = XLEN'($signed(imm32));
        dec_tgt = pcrel ? in_pc + dec_imm : (is_lui ? dec_imm : '0);
    end

    logic [1:0][XLEN-1:0] imm_q, tgt_q, pc_q;
    logic [1:0][2:0]      fmt_q;
    logic [1:0]           ill_q;
    logic [1:0]           cnt_q, cnt_d;
    logic                 head_q, head_d, tail_q, tail_d;
    logic                 push, pop;

    // in_ready depends on registered count only, so out_ready never reaches it.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Pointer/count bookkeeping; flush wins over any push or pop in the same cycle.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            cnt_d  = '0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; written at the tail on accept, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= '0;
            tgt_q <= '0;
            pc_q  <= '0;
            fmt_q <= '0;
            ill_q <= '0;
        end else if (push) begin
            imm_q[tail_q] <= dec_imm;
            tgt_q[tail_q] <= dec_tgt;
            pc_q[tail_q]  <= in_pc;
            fmt_q[tail_q] <= dec_fmt;
            ill_q[tail_q] <= dec_ill;
        end
    end

    // Head entry drives the outputs; an empty buffer presents all zeros.
    always_comb begin
        out_imm     = '0;
        out_target  = '0;
        out_pc      = '0;
        out_fmt     = F_NONE;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm     = imm_q[head_q];
            out_target  = tgt_q[head_q];
            out_pc      = pc_q[head_q];
            out_fmt     = fmt_q[head_q];
            out_illegal = ill_q[head_q];
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN32/zicsr, XLEN64/zicsr, XLEN64/no-zicsr)
// share one stimulus stream; each has its own expected-entry queue fed by a
// reference decoder and drained by a negedge monitor.
module tb_imm_gen_pipe;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    always #5 clk = ~clk;

    logic        ir_a, ov_a, ill_a, ir_b, ov_b, ill_b, ir_c, ov_c, ill_c;
    logic [2:0]  fmt_a, fmt_b, fmt_c;
    logic [31:0] imm_a, tgt_a, pc_a;
    logic [63:0] imm_b, tgt_b, pc_b, imm_c, tgt_c, pc_c;

    imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov_a), .out_ready(out_ready),
        .out_imm(imm_a), .out_fmt(fmt_a), .out_target(tgt_a), .out_illegal(ill_a), .out_pc(pc_a));
    imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_b), .out_ready(out_ready),
        .out_imm(imm_b), .out_fmt(fmt_b), .out_target(tgt_b), .out_illegal(ill_b), .out_pc(pc_b));
    imm_gen_pipe #(.XLEN(64), .EN_ZICSR(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_c), .out_ready(out_ready),
        .out_imm(imm_c), .out_fmt(fmt_c), .out_target(tgt_c), .out_illegal(ill_c), .out_pc(pc_c));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    exp_t q[3][$];
    int   checks = 0, errors = 0;
    bit   exp_rdy = 1'b0, last_acc = 1'b0;
    int   xl[3] = '{32, 64, 64};
    bit   zc[3] = '{1'b1, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Sign-extend the low 'bits' bits of v to 64 bits.
    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic signed [63:0] s;
        s = $signed(v << (64 - bits));
        return 64'(s >>> (64 - bits));
    endfunction

    // Reference decoder straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc,
                                   input int xlen, input bit zicsr);
        exp_t        r;
        logic [63:0] m;
        logic [6:0]  op;
        op = i[6:0];
        r  = '{imm: 64'd0, fmt: 3'd0, tgt: 64'd0, ill: 1'b0, pc: 64'd0};
        m  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (op)
            7'h13, 7'h03, 7'h67: begin r.fmt = 3'd1; r.imm = sx(64'(i[31:20]), 12); end
            7'h1B: if (xlen == 64) begin r.fmt = 3'd1; r.imm = sx(64'(i[31:20]), 12); end
                   else r.ill = 1'b1;
            7'h23: begin r.fmt = 3'd2; r.imm = sx(64'({i[31:25], i[11:7]}), 12); end
            7'h63: begin r.fmt = 3'd3;
                         r.imm = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); end
            7'h6F: begin r.fmt = 3'd5;
                         r.imm = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); end
            7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = sx(64'({i[31:12], 12'h000}), 32); end
            7'h73: if (zicsr && i[14]) begin r.fmt = 3'd6; r.imm = 64'(i[19:15]); end
            7'h33, 7'h0F: ;
            7'h3B: r.ill = (xlen != 64);
            default: r.ill = 1'b1;
        endcase
        r.imm = r.imm & m;
        if (op == 7'h63 || op == 7'h6F || op == 7'h17) r.tgt = (pc + r.imm) & m;
        else if (op == 7'h37) r.tgt = r.imm;
        r.pc = pc & m;
        return r;
    endfunction

    // Compare one instance against the head of its queue (empty queue => idle zeros).
    task automatic mon(input int k, input logic ov, input logic ir, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic [63:0] tgt, input logic ill,
                       input logic [63:0] pc);
        exp_t e;
        bit   has;
        has = (q[k].size() != 0);
        e   = '{imm: 64'd0, fmt: 3'd0, tgt: 64'd0, ill: 1'b0, pc: 64'd0};
        if (has) e = q[k][0];
        chk($sformatf("d%0d out_valid", k), 64'(ov), 64'(has));
        chk($sformatf("d%0d in_ready", k), 64'(ir), 64'(q[k].size() < 2));
        chk($sformatf("d%0d out_imm", k), imm, e.imm);
        chk($sformatf("d%0d out_fmt", k), 64'(fmt), 64'(e.fmt));
        chk($sformatf("d%0d out_target", k), tgt, e.tgt);
        chk($sformatf("d%0d out_illegal", k), 64'(ill), 64'(e.ill));
        chk($sformatf("d%0d out_pc", k), pc, e.pc);
    endtask

    task automatic checkall();
        mon(0, ov_a, ir_a, 64'(imm_a), fmt_a, 64'(tgt_a), ill_a, 64'(pc_a));
        mon(1, ov_b, ir_b, imm_b, fmt_b, tgt_b, ill_b, pc_b);
        mon(2, ov_c, ir_c, imm_c, fmt_c, tgt_c, ill_c, pc_c);
    endtask

    // Monitor: check the head, then retire it / flush as the coming edge will.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) q[k].delete();
            checkall();
            exp_rdy = 1'b0;
        end else begin
            checkall();
            exp_rdy = (q[0].size() < 2);
            if (flush) begin
                for (int k = 0; k < 3; k++) q[k].delete();
            end else if (out_ready && q[0].size() != 0) begin
                for (int k = 0; k < 3; k++) void'(q[k].pop_front());
            end
        end
    end

    // One clock of stimulus; expected entries are queued when the model accepts.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        @(posedge clk); #1;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        @(negedge clk); #2;
        last_acc = rst_n && v && !fl && exp_rdy;
        if (last_acc)
            for (int k = 0; k < 3; k++) q[k].push_back(model(ins, pc, xl[k], zc[k]));
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc, input logic ordy);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            cycle(1'b1, ins, pc, ordy, 1'b0);
            acc = last_acc;
        end
        checks++;
        if (!acc) begin errors++; $display("FAIL send timeout actual=stalled required=accepted"); end
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && q[0].size() != 0; n++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        checks++;
        if (q[0].size() != 0) begin
            errors++;
            $display("FAIL drain timeout actual=%0d left required=0", q[0].size());
        end
    endtask

    // Accept one word with out_ready low so it sits at the head afterwards.
    task automatic put(input logic [31:0] ins, input logic [63:0] pc);
        cycle(1'b1, ins, pc, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    logic [6:0] ops[14] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F,
                            7'h37, 7'h17, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h7F};

    initial begin
        logic [31:0] r, ins;
        logic [63:0] pc;

        @(posedge clk); #1 rst_n = 1'b1;

        // Directed decode cases, checked against literal expectations at the head.
        put(32'hFFF00093, 64'h0);
        chk("addi imm", 64'(imm_a), 64'hFFFF_FFFF);
        chk("addi fmt", 64'(fmt_a), 64'd1);
        chk("addi tgt", 64'(tgt_a), 64'd0);
        chk("addi ill", 64'(ill_a), 64'd0);
        pop1();
        put(32'hFE000EE3, 64'h100);
        chk("beq imm", 64'(imm_a), 64'hFFFF_FFFC);
        chk("beq fmt", 64'(fmt_a), 64'd3);
        chk("beq tgt", 64'(tgt_a), 64'hFC);
        pop1();
        put(32'h0080006F, 64'h1000);
        chk("jal imm", 64'(imm_a), 64'd8);
        chk("jal fmt", 64'(fmt_a), 64'd5);
        chk("jal tgt", 64'(tgt_a), 64'h1008);
        pop1();
        put(32'h800000B7, 64'h40);
        chk("lui64 imm", imm_b, 64'hFFFF_FFFF_8000_0000);
        chk("lui64 fmt", 64'(fmt_b), 64'd4);
        chk("lui64 tgt", tgt_b, 64'hFFFF_FFFF_8000_0000);
        pop1();
        put(32'h000FD073, 64'h80);
        chk("csrrwi imm", imm_b, 64'h1F);
        chk("csrrwi fmt", 64'(fmt_b), 64'd6);
        chk("csrrwi nozicsr fmt", 64'(fmt_c), 64'd0);
        chk("csrrwi nozicsr ill", 64'(ill_c), 64'd0);
        chk("csrrwi nozicsr imm", imm_c, 64'd0);
        pop1();
        put(32'h0000007F, 64'h84);
        chk("op7f ill", 64'(ill_b), 64'd1);
        chk("op7f imm", imm_b, 64'd0);
        pop1();
        put(32'h0010009B, 64'h88); // addiw: legal on 64, illegal on 32
        chk("addiw32 ill", 64'(ill_a), 64'd1);
        chk("addiw64 fmt", 64'(fmt_b), 64'd1);
        pop1();

        // Backpressure: C is refused while full, then flows after the first pop.
        cycle(1'b1, 32'h00A00093, 64'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00B00093, 64'h204, 1'b0, 1'b0);
        cycle(1'b1, 32'h00C00093, 64'h208, 1'b0, 1'b0);
        chk("C refused when full", 64'(ir_a), 64'd0);
        send(32'h00C00093, 64'h208, 1'b1);
        drain();

        // Flush with two entries while a new word is offered.
        cycle(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 64'h304, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 64'h308, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("post-flush out_valid", 64'(ov_a), 64'd0);
        chk("post-flush in_ready", 64'(ir_a), 64'd1);

        // Asynchronous reset mid-stream with one entry held.
        put(32'h12345037, 64'h400);
        @(posedge clk); #3;
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) q[k].delete();
        checkall();
        @(posedge clk); #1 rst_n = 1'b1;
        send(32'h0080006F, 64'h500, 1'b1);
        drain();

        // Random soak.
        for (int n = 0; n < 2000; n++) begin
            r = $urandom();
            ins = $urandom();
            if (r[3:0] < 4'd14) ins[6:0] = ops[r[3:0]];
            pc = {32'($urandom()), 32'($urandom())};
            cycle(r[6:4] != 3'd0, ins, pc, r[8:7] != 2'd0, r[15:10] == 6'd0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, handshaked immediate-generation stage for the decode pipeline. It generalises the combinational immediate generator to XLEN 32 or 64 and adds RV64 OP-IMM-32 and Zicsr zimm formats. It also reports format and illegal-opcode flags and precomputes the PC-relative target (pc + imm). A 2-entry skid buffer with valid/ready on both sides sits between fetch and the decode/execute boundary; a synchronous flush squashes all buffered entries.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64 only.
- EN_ZICSR, 1: 1 decodes CSR-immediate (zimm) forms; 0 treats them as NONE.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream presents instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_target  out  XLEN  PC-relative result; see Operation.
- out_illegal  out  1  opcode not recognised.
- out_pc  out  XLEN  PC carried with entry.

## Operation
- Decode on in_instr[6:0]; the result is computed combinationally and written into the buffer on accept:
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR: I.
  - 0011011 OP-IMM-32: I when XLEN=64, illegal when XLEN=32.
  - 0100011 STORE: S.
  - 1100011 BRANCH: B.
  - 1101111 JAL: J.
  - 0110111 LUI, 0010111 AUIPC: U.
  - 1110011 SYSTEM with funct3[2]=1 and EN_ZICSR=1: Z. imm = zero-extend in_instr[19:15].
  - Other SYSTEM, 0110011 OP, 0111011 OP-32 (XLEN=64 only), 0001111 MISC-MEM: NONE, imm=0, not illegal.
  - Any other opcode: fmt NONE, imm 0, illegal=1.
- Extension: I/S/B/J/U are sign-extended from instr[31] to XLEN. U = {instr[31:12],12'b0}, sign-extended to XLEN, so RV64 LUI with bit31 set yields upper ones.
- out_target, computed modulo 2^XLEN:
  - in_pc + imm for B, J and AUIPC.
  - imm for LUI.
  - 0 for all other formats, including JALR.
- Buffer: 2-entry FIFO, count in {0,1,2}, each entry holds {imm, fmt, target, illegal, pc}.
  - in_ready = (count != 2). It is a function of registered state only; there is no combinational path from out_ready.
  - Accept when in_valid & in_ready. Pop when out_valid & out_ready.
  - Simultaneous push and pop with count=1 or 2: count unchanged, order preserved.
  - Push with count=2 is impossible because in_ready=0.
- out_valid = (count != 0). The out_* fields show the head entry. When count=0 the out_* fields are all 0.
- Flush: at the clock edge, count becomes 0 and the head and tail pointers reset.
  - Any input presented in the flush cycle is dropped, even if in_ready=1.
  - Any output pop in the flush cycle is ignored.
- Reset (async, any time, including mid-transfer): count=0, pointers=0, entry storage cleared. Outputs while reset is held: in_ready=1, out_valid=0, all out_* fields 0.

## Timing
- Latency: an instruction accepted at edge N is at the head with out_valid=1 after edge N when the buffer was empty. The minimum input-to-output latency is 1 cycle.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Holding out_ready=0 fills the buffer after 2 accepts; in_ready falls the cycle after the second accept.
- Backpressure release: after out_ready rises with count=2, in_ready returns high one cycle after the first pop.
- Outputs are stable while out_valid=1 and out_ready=0.
- Deassertion of rst_n is synchronised externally. The first accept may occur on the first edge after release.

## Test plan
- XLEN=32, in_instr 0xFFF00093 (addi x1,x0,-1), in_pc 0x0 -> out_imm 0xFFFFFFFF, fmt 1, target 0, illegal 0, one cycle later.
- XLEN=32, in_instr 0xFE000EE3 (beq -4), in_pc 0x100 -> imm 0xFFFFFFFC, fmt 3, target 0xFC. Then 0x0080006F (jal +8), pc 0x1000 -> imm 8, fmt 5, target 0x1008.
- XLEN=64: in_instr 0x800000B7 (lui) -> imm 0xFFFFFFFF80000000, fmt 4, target = imm. With 0x000FD073 (csrrwi zimm 31) -> imm 0x1F, fmt 6. With EN_ZICSR=0 -> fmt 0, illegal 0. Opcode 0x7F -> illegal 1, imm 0.
- Backpressure: out_ready=0, stream A, B, C with in_valid=1 -> A and B accepted, in_ready=0 for C. Raise out_ready -> outputs A, B, C in order with no loss or duplication. A random valid/ready soak against a reference model matches.
- Flush with count=2 while in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle input is absent from the output.
- Assert rst_n=0 mid-stream with count=1 -> out_valid=0 immediately (async), all out_* 0, in_ready=1. After release, a new instruction flows normally.
